// File: rtl/mem_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_seq_ctrl_if
// Purpose  : Stream and memory-bus signals of the memory fill/dump sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_seq_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: the sequencer; slave: the surrounding stream sources/sinks and memory
  modport master (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_seq_ctrl
// Purpose  : Fills a small register memory from a valid/ready stream or dumps
//            it to a valid/ready stream. Optional macro MEM_SEQ_CHECKSUM_EN
//            adds an XOR checksum output over the words moved.
// Revision : 1.0 - initial release
// ============================================================================
module mem_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 1
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       start,
  input  wire logic       mode,
  mem_seq_ctrl_if.master  bus,
  output logic            busy,
  output logic            done
`ifdef MEM_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_OUT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] chk_q, chk_d;

  logic in_fill;
  assign in_fill = (state_q == S_FILL);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    chk_d       = chk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          chk_d   = '0;
          state_d = mode ? S_RD_WAIT : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.in_valid) begin
          chk_d  = chk_q ^ bus.in_data;
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      // Memory samples mem_addr on the falling edge inside this cycle.
      S_RD_WAIT: begin
        out_data_d  = bus.mem_rdata;
        out_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          chk_d       = chk_q ^ out_data_q;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD_WAIT;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done_q is set on entry to DONE so it is high for exactly that one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      chk_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      chk_q       <= chk_d;
    end
  end

  assign bus.in_ready  = in_fill;
  assign bus.mem_we    = in_fill & bus.in_valid;
  assign bus.mem_wdata = in_fill ? bus.in_data : '0;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

`ifdef MEM_SEQ_CHECKSUM_EN
  assign checksum = chk_q;
`else
  logic unused_chk;
  assign unused_chk = ^chk_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_seq_ctrl
// Purpose  : Directed self-checking bench for mem_seq_ctrl with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_seq_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic busy;
  logic done;
`ifdef MEM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  mem_seq_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done)
`ifdef MEM_SEQ_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Memory: synchronous write on rising edge, read registered on falling edge.
  logic [DATA_W-1:0] mem [2];
  always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  always @(negedge clock) bus.mem_rdata <= mem[bus.mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Asynchronous reset while clock is low
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    tick();
    tick();
    reset = 1'b0;

    // FILL with a 2-cycle stall and an ignored start
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    check("fill_busy", busy, 1);
    check("fill_in_ready", bus.in_ready, 1);
    check("fill_out_valid", bus.out_valid, 0);
    check("stall0_we", bus.mem_we, 0);
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    check("stall1_we", bus.mem_we, 0);
    check("stall1_addr", bus.mem_addr, 0);
    check("stall1_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b1; bus.in_data = 4'hA;
    #1;
    check("w0_we", bus.mem_we, 1);
    check("w0_addr", bus.mem_addr, 0);
    check("w0_wdata", bus.mem_wdata, 4'hA);
    tick();
    bus.in_data = 4'h5;
    #1;
    check("w1_we", bus.mem_we, 1);
    check("w1_addr", bus.mem_addr, 1);
    check("w1_wdata", bus.mem_wdata, 4'h5);
    tick();
    bus.in_valid = 1'b0;
    check("fill_done", done, 1);
    check("fill_done_busy", busy, 1);
    check("fill_done_we", bus.mem_we, 0);
`ifdef MEM_SEQ_CHECKSUM_EN
    check("fill_checksum", checksum, 4'hF);
`endif
    tick();
    check("fill_idle_done", done, 0);
    check("fill_idle_busy", busy, 0);
    check("fill_idle_addr", bus.mem_addr, 0);
    check("mem0_after_fill", mem[0], 4'hA);
    check("mem1_after_fill", mem[1], 4'h5);

    // DUMP with 3 cycles of backpressure; in_valid must not write
    start = 1'b1; mode = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'h3;
    tick();
    start = 1'b0;
    check("rdw_busy", busy, 1);
    check("rdw_out_valid", bus.out_valid, 0);
    check("rdw_in_ready", bus.in_ready, 0);
    check("rdw_we", bus.mem_we, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 4'hA);
      check("bp_addr", bus.mem_addr, 0);
      check("bp_we", bus.mem_we, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("rdw1_out_valid", bus.out_valid, 0);
    check("rdw1_addr", bus.mem_addr, 1);
    tick();
    check("rd1_out_valid", bus.out_valid, 1);
    check("rd1_out_data", bus.out_data, 4'h5);
    tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    check("dump_done", done, 1);
    check("dump_done_out_valid", bus.out_valid, 0);
`ifdef MEM_SEQ_CHECKSUM_EN
    check("dump_checksum", checksum, 4'hF);
`endif
    tick();
    check("dump_idle_done", done, 0);
    check("dump_idle_busy", busy, 0);
    check("mem0_after_dump", mem[0], 4'hA);
`ifdef MEM_SEQ_CHECKSUM_EN
    check("checksum_stable", checksum, 4'hF);
`endif

    // Abort a FILL after its first handshake
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    check("abort_pre_addr", bus.mem_addr, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", bus.mem_addr, 0);
    check("abort_in_ready", bus.in_ready, 0);
    tick();
    check("abort_no_done", done, 0);
    check("abort_mem0_kept", mem[0], 4'h3);
    reset = 1'b0;

    // Fresh fill starts at address 0
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'hC;
    #1;
    check("refill_addr0", bus.mem_addr, 0);
    check("refill_we", bus.mem_we, 1);
    tick();
    bus.in_data = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    check("refill_done", done, 1);
`ifdef MEM_SEQ_CHECKSUM_EN
    check("refill_checksum", checksum, 4'hA);
`endif
    tick();
    check("refill_mem0", mem[0], 4'hC);
    check("refill_mem1", mem[1], 4'h6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
